pipe_reg_chain: RTL and testbench

//  Parametrised elastic register pipeline, successor to the single enabled D flip-flop.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/pipe_stage.sv | 30 +++
 rtl/pipe_reg_chain.sv | 84 ++++++++
 tb/tb_pipe_reg_chain.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
package pipe_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register of the elastic pipeline; loads its predecessor on adv, empties on clr.
// Latency 1 cycle; holds its contents whenever adv is low.
module pipe_stage #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (adv) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic register pipeline with bubble collapse, global hold and flush.
// Latency DEPTH cycles unblocked; in_ready follows out_ready combinationally through the adv chain.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] prev_v;
    logic [WIDTH-1:0] prev_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             carry;
    logic [OW-1:0]    cnt;

    // Walk from the output back to the input so an empty stage always fills.
    always_comb begin
        carry          = en & ~clr & (~v[DEPTH-1] | out_ready);
        adv            = '0;
        adv[DEPTH-1]   = carry;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            carry  = en & ~clr & (~v[i] | carry);
            adv[i] = carry;
        end
    end

    genvar g;
    generate
        for (g = 0; g < int'(DEPTH); g++) begin : g_stage
            if (g == 0) begin : g_head
                assign prev_v[g] = in_valid;
                assign prev_d[g] = in_data;
            end else begin : g_body
                assign prev_v[g] = v[g-1];
                assign prev_d[g] = d[g-1];
            end

            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .adv        (adv[g]),
                .clr        (clr),
                .prev_valid (prev_v[g]),
                .prev_data  (prev_d[g]),
                .valid      (v[g]),
                .data       (d[g])
            );
        end
    endgenerate

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt = cnt + OW'(v[i]);
        end
    end

    // Reset gating keeps the input closed while rst is held low.
    assign in_ready  = adv[0] & rst;
    assign out_valid = en & ~clr & v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed vector bench for pipe_reg_chain (WIDTH=8, DEPTH=3, RESET_VAL=0).
module tb_pipe_reg_chain;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    int tests;
    int errors;

    pipe_reg_chain #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ovld;
        logic [7:0] e_data;
        logic       chk_d;
        logic [1:0] e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic c, input logic iv, input logic [7:0] id,
                                input logic ordy, input logic irdy, input logic ovld,
                                input logic [7:0] dat, input logic chkd, input logic [1:0] occ);
        vec_t t;
        t.en = e; t.clr = c; t.iv = iv; t.id = id; t.ordy = ordy;
        t.e_irdy = irdy; t.e_ovld = ovld; t.e_data = dat; t.chk_d = chkd; t.e_occ = occ;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        en        = t.en;
        clr       = t.clr;
        in_valid  = t.iv;
        in_data   = t.id;
        out_ready = t.ordy;
        #1;
        chk($sformatf("v%0d_in_ready", idx),  32'(in_ready),  32'(t.e_irdy));
        chk($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'(t.e_ovld));
        chk($sformatf("v%0d_occupancy", idx), 32'(occupancy), 32'(t.e_occ));
        if (t.chk_d)
            chk($sformatf("v%0d_out_data", idx), 32'(out_data), 32'(t.e_data));
    endtask

    initial begin
        tests     = 0;
        errors    = 0;
        rst       = 1'b0;
        en        = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state while rst is held low
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b1;

        // Reset mid-cycle with two items held
        apply(mk(1,0,1,8'hD1,0, 1,0,8'h00,0,2'd0), 100);
        apply(mk(1,0,1,8'hD2,0, 1,0,8'h00,0,2'd1), 101);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'h00);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        //          en clr iv data  ordy irdy ovld data  chk occ
        // Stream
        vecs.push_back(mk(1,0,1,8'h11,1, 1,0,8'h00,0,2'd0));
        vecs.push_back(mk(1,0,1,8'h22,1, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,0,1,8'h33,1, 1,0,8'h00,0,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h11,1,2'd3));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h22,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h33,1,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0,2'd0));
        // Backpressure
        vecs.push_back(mk(1,0,1,8'hA1,0, 1,0,8'h00,0,2'd0));
        vecs.push_back(mk(1,0,1,8'hA2,0, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,0,1,8'hA3,0, 1,0,8'h00,0,2'd2));
        vecs.push_back(mk(1,0,1,8'hA4,0, 0,1,8'hA1,1,2'd3));
        vecs.push_back(mk(1,0,1,8'hA4,1, 1,1,8'hA1,1,2'd3));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA2,1,2'd3));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA3,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA4,1,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0,2'd0));
        // Bubble collapse
        vecs.push_back(mk(1,0,1,8'h5A,0, 1,0,8'h00,0,2'd0));
        vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,0,1,8'h5B,0, 1,1,8'h5A,1,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,0, 1,1,8'h5A,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,0, 1,1,8'h5A,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h5A,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h5B,1,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0,2'd0));
        // Freeze
        vecs.push_back(mk(1,0,1,8'hB1,0, 1,0,8'h00,0,2'd0));
        vecs.push_back(mk(1,0,1,8'hB2,0, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,0,1,8'hB3,0, 1,0,8'h00,0,2'd2));
        vecs.push_back(mk(0,0,1,8'hB4,1, 0,0,8'hB1,1,2'd3));
        vecs.push_back(mk(0,0,1,8'hB4,1, 0,0,8'hB1,1,2'd3));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB1,1,2'd3));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB2,1,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB3,1,2'd1));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0,2'd0));
        // Flush
        vecs.push_back(mk(1,0,1,8'hC1,0, 1,0,8'h00,0,2'd0));
        vecs.push_back(mk(1,0,1,8'hC2,0, 1,0,8'h00,0,2'd1));
        vecs.push_back(mk(1,1,1,8'hFF,1, 0,0,8'h00,0,2'd2));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,1,2'd0));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,1,2'd0));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,1,2'd0));
        vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,1,2'd0));

        foreach (vecs[i]) apply(vecs[i], i);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
